gate_chip_tester: RTL and testbench
===================================

// Module: gate_chip_tester
// PURPOSE
//  Parametrised exhaustive tester for 74xx single-function gate chips: NUM_GATES gates, 1..MAX_INPUTS inputs each.
//  Sweeps every input vector, waits a settle time, samples gate outputs and compares against the selected function.
//  Reports per-gate fail mask, first failing vector and pass/fail. Sits between selection FSM and chip pin tristates.
// PARAMETERS
//  NUM_GATES      4      gates per chip
//  MAX_INPUTS     3      max inputs per gate (vector width)
//  SETTLE_CYCLES  50000  Clk cycles between applying a vector and sampling; >=3
// PORTS
//  Clk            in   1                        system clock
//  Reset          in   1                        asynchronous, active-high reset
//  Start          in   1                        begin test; sampled in IDLE only
//  Abort          in   1                        cancel test in progress
//  Func           in   3                        0 AND,1 NAND,2 OR,3 NOR,4 XOR,5 XNOR,6 BUF,7 INV
//  NumInputs      in   $clog2(MAX_INPUTS+1)     inputs used per gate
//  GateMask       in   NUM_GATES                1 = gate checked
//  SenseOut       in   NUM_GATES                gate outputs from chip pins (asynchronous)
//  DrvIn          out  NUM_GATES*MAX_INPUTS     gate g inputs at [g*MAX_INPUTS +: MAX_INPUTS]
//  DrvEn          out  1                        enables input-pin tristate drivers
//  Busy           out  1                        high from accept to Done
//  Done           out  1                        one-cycle pulse at end of test
//  Pass           out  1                        held until next Start
//  ConfigErr      out  1                        held until next Start
//  FailMask       out  NUM_GATES                accumulated mismatches, held
//  FirstFailVec   out  MAX_INPUTS               vector of first mismatch
//  FirstFailValid out  1                        FirstFailVec meaningful
// BEHAVIOUR
//  Reset: state IDLE; DrvIn=0, DrvEn=0, Busy=0, Done=0, Pass=0, ConfigErr=0, FailMask=0, FirstFailVec=0,
//   FirstFailValid=0; synchroniser flops cleared. Reset mid-test aborts immediately.
//  Func, NumInputs, GateMask latched on accepted Start; later changes ignored until next test.
//  Illegal config: NumInputs=0, NumInputs>MAX_INPUTS, Func 6/7 with NumInputs!=1, or GateMask=0.
//   -> go to DONE next cycle, ConfigErr=1, Pass=0, DrvEn stays 0.
//  FSM: IDLE -Start-> APPLY (1 cyc) -> SETTLE (SETTLE_CYCLES cyc) -> SAMPLE (1 cyc)
//   -> APPLY if vector != 2^NumInputs-1, else DONE (1 cyc, Done=1) -> IDLE.
//  Start in IDLE clears FailMask, FirstFailValid, Pass, ConfigErr. Start while Busy: ignored.
//  Vector counter v starts at 0, incremented in SAMPLE. Every gate receives the same vector.
//  Input bits i<NumInputs = v[i]. Unused bits = identity: 1 for AND/NAND, 0 for others.
//  DrvEn=1 from APPLY through SAMPLE; DrvIn held stable across SETTLE.
//  SenseOut passes through a 2-flop synchroniser; SETTLE_CYCLES includes its latency.
//  SAMPLE: exp = f(v[NumInputs-1:0]); mism = (sync ^ {NUM_GATES{exp}}) & GateMask.
//   FailMask |= mism. If mism!=0 and !FirstFailValid: capture FirstFailVec=v, FirstFailValid=1.
//  DONE: Pass = (FailMask==0) && !ConfigErr.
//  Latency, legal config: Done high 2^NumInputs*(SETTLE_CYCLES+2)+1 cycles after Start edge.
//  Abort (any non-IDLE state, priority over Start/SAMPLE): next cycle IDLE, DrvEn=0, Busy=0, Pass=0,
//   no Done pulse, FailMask/FirstFail* keep partial values. Abort in IDLE: no effect.
//  Settle counter: width $clog2(SETTLE_CYCLES+1), reloads on each APPLY, never wraps.
// STRUCTURE
//  gate_tester_pkg: gate_func_e enum (8 codes), tester_state_e enum, function gate_eval(func,vec,n),
//   function gate_identity(func).
//  Sub-module sense_sync: NUM_GATES-wide 2-flop synchroniser, async-reset to 0.
// TESTING (sim with SETTLE_CYCLES=4, NUM_GATES=4, MAX_INPUTS=3)
//  1. Good 7400 model, Func=1, NumInputs=2, GateMask=F, Start -> Done at cycle 4*6+1=25, Pass=1, FailMask=0.
//  2. 7400 with gate 2 stuck-at-1 -> Pass=0, FailMask=4'b0100, FirstFailVec=3'b011, FirstFailValid=1.
//  3. Good 7410 model, Func=1, NumInputs=3, GateMask=4'b0111 -> 8 vectors, Done at cycle 49, Pass=1.
//     Gate 3 floating: no effect.
//  4. Func=7, NumInputs=2 -> Done 2 cycles after Start, ConfigErr=1, Pass=0, DrvEn never 1.
//  5. Abort during 2nd SETTLE -> Busy=0 and DrvEn=0 next cycle, no Done pulse; Start pulse mid-test ignored.
//  6. Reset asserted mid-SETTLE -> all outputs 0 asynchronously; a new Start then completes a normal 7402 NOR pass.

Source files
------------

// File: rtl/gate_tester_pkg.sv
// Shared types and gate-function helpers for the 74xx gate-chip tester.
// Combinational helpers only, no latency.
// No flow control.
package gate_tester_pkg;

    // Widest vector the helper functions accept; the tester's MAX_INPUTS must not exceed it.
    localparam int VEC_W = 8;

    typedef enum logic [2:0] {
        FN_AND  = 3'd0,
        FN_NAND = 3'd1,
        FN_OR   = 3'd2,
        FN_NOR  = 3'd3,
        FN_XOR  = 3'd4,
        FN_XNOR = 3'd5,
        FN_BUF  = 3'd6,
        FN_INV  = 3'd7
    } gate_func_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } tester_state_e;

    // Level driven onto unused gate inputs so they do not disturb the result.
    function automatic logic gate_identity(gate_func_e func);
        return (func == FN_AND) || (func == FN_NAND);
    endfunction

    // Reference output of one gate for the low n bits of vec.
    function automatic logic gate_eval(gate_func_e func, logic [VEC_W-1:0] vec, int n);
        logic all_ones;
        logic any_one;
        logic parity;
        logic res;
        all_ones = 1'b1;
        any_one  = 1'b0;
        parity   = 1'b0;
        for (int i = 0; i < VEC_W; i++) begin
            if (i < n) begin
                all_ones = all_ones & vec[i];
                any_one  = any_one | vec[i];
                parity   = parity ^ vec[i];
            end
        end
        case (func)
            FN_AND:  res = all_ones;
            FN_NAND: res = ~all_ones;
            FN_OR:   res = any_one;
            FN_NOR:  res = ~any_one;
            FN_XOR:  res = parity;
            FN_XNOR: res = ~parity;
            FN_BUF:  res = vec[0];
            FN_INV:  res = ~vec[0];
            default: res = all_ones;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sense_sync.sv
// Two-flop synchroniser for the asynchronous gate-output pins.
// Latency: 2 clk cycles. No flow control.
// Ports: clk, rst (async, active-high), sense (raw pins), synced (clk-domain copy).
module sense_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sense,
    output logic [WIDTH-1:0] synced
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= '0;
            synced <= '0;
        end else begin
            meta   <= sense;
            synced <= meta;
        end
    end

endmodule

// File: rtl/gate_chip_tester.sv
// Exhaustive tester for single-function 74xx gate chips: sweeps all input vectors, samples, compares.
// Latency: Done pulses 2^NumInputs*(SETTLE_CYCLES+2)+1 cycles after Start; 2 cycles on bad config.
// No backpressure: Start ignored while Busy, Abort returns to IDLE in one cycle.
// Ports: Clk/Reset; Start/Abort control; Func/NumInputs/GateMask config (latched on Start);
//  SenseOut chip outputs; DrvIn/DrvEn chip input drivers; Busy/Done/Pass/ConfigErr status;
//  FailMask/FirstFailVec/FirstFailValid diagnostics.
module gate_chip_tester
    import gate_tester_pkg::*;
#(
    parameter int NUM_GATES     = 4,
    parameter int MAX_INPUTS    = 3,
    parameter int SETTLE_CYCLES = 50000
) (
    input  logic                              Clk,
    input  logic                              Reset,
    input  logic                              Start,
    input  logic                              Abort,
    input  logic [2:0]                        Func,
    input  logic [$clog2(MAX_INPUTS+1)-1:0]   NumInputs,
    input  logic [NUM_GATES-1:0]              GateMask,
    input  logic [NUM_GATES-1:0]              SenseOut,
    output logic [NUM_GATES*MAX_INPUTS-1:0]   DrvIn,
    output logic                              DrvEn,
    output logic                              Busy,
    output logic                              Done,
    output logic                              Pass,
    output logic                              ConfigErr,
    output logic [NUM_GATES-1:0]              FailMask,
    output logic [MAX_INPUTS-1:0]             FirstFailVec,
    output logic                              FirstFailValid
);

    localparam int NW = $clog2(MAX_INPUTS + 1);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    tester_state_e          state, nstate;
    gate_func_e             func_q;
    logic [NW-1:0]          nin_q;
    logic [NUM_GATES-1:0]   mask_q;
    logic [MAX_INPUTS-1:0]  vec_q;
    logic [CW-1:0]          cnt_q;
    logic [NUM_GATES-1:0]   sense_s;
    logic                   done_q, pass_q, cfg_err_q, ffvalid_q;
    logic [NUM_GATES-1:0]   fail_q;
    logic [MAX_INPUTS-1:0]  ffv_q;

    logic                   accept, abort_act, cfg_bad, last_vec, exp_bit, drv_en;
    logic [NUM_GATES-1:0]   mism;

    sense_sync #(.WIDTH(NUM_GATES)) u_sync (
        .clk    (Clk),
        .rst    (Reset),
        .sense  (SenseOut),
        .synced (sense_s)
    );

    assign accept    = (state == ST_IDLE) && Start;
    assign abort_act = (state != ST_IDLE) && Abort;

    // Evaluated on the latched config, so it is valid from the first cycle after accept.
    assign cfg_bad = (nin_q == '0) || (int'(nin_q) > MAX_INPUTS) || (mask_q == '0) ||
                     (((func_q == FN_BUF) || (func_q == FN_INV)) && (nin_q != NW'(1)));

    assign last_vec = (int'(vec_q) == ((1 << int'(nin_q)) - 1));
    assign exp_bit  = gate_eval(func_q, VEC_W'(vec_q), int'(nin_q));
    assign mism     = (sense_s ^ {NUM_GATES{exp_bit}}) & mask_q;

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= ST_IDLE;
        else       state <= nstate;
    end

    // Next-state logic; Abort overrides everything outside IDLE
    always_comb begin
        nstate = state;
        case (state)
            ST_IDLE:   if (Start) nstate = ST_APPLY;
            ST_APPLY:  nstate = cfg_bad ? ST_DONE : ST_SETTLE;
            ST_SETTLE: if (cnt_q == '0) nstate = ST_SAMPLE;
            ST_SAMPLE: nstate = last_vec ? ST_DONE : ST_APPLY;
            ST_DONE:   nstate = ST_IDLE;
            default:   nstate = ST_IDLE;
        endcase
        if (abort_act) nstate = ST_IDLE;
    end

    // Outputs; a bad config never enables the pin drivers
    always_comb begin
        drv_en = ((state == ST_APPLY) || (state == ST_SETTLE) || (state == ST_SAMPLE)) && !cfg_bad;
        DrvIn  = '0;
        for (int g = 0; g < NUM_GATES; g++) begin
            for (int i = 0; i < MAX_INPUTS; i++) begin
                if (drv_en)
                    DrvIn[g*MAX_INPUTS + i] = (i < int'(nin_q)) ? vec_q[i] : gate_identity(func_q);
            end
        end
        DrvEn          = drv_en;
        Busy           = (state != ST_IDLE);
        Done           = done_q;
        Pass           = pass_q;
        ConfigErr      = cfg_err_q;
        FailMask       = fail_q;
        FirstFailVec   = ffv_q;
        FirstFailValid = ffvalid_q;
    end

    // Config latch, sweep counters and result registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            func_q    <= FN_AND;
            nin_q     <= '0;
            mask_q    <= '0;
            vec_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            fail_q    <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                func_q    <= gate_func_e'(Func);
                nin_q     <= NumInputs;
                mask_q    <= GateMask;
                vec_q     <= '0;
                fail_q    <= '0;
                ffvalid_q <= 1'b0;
                pass_q    <= 1'b0;
                cfg_err_q <= 1'b0;
            end else if (abort_act) begin
                pass_q <= 1'b0;
            end else begin
                case (state)
                    ST_APPLY:  cnt_q <= CW'(SETTLE_CYCLES - 1);
                    ST_SETTLE: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                    ST_SAMPLE: begin
                        fail_q <= fail_q | mism;
                        if ((mism != '0) && !ffvalid_q) begin
                            ffv_q     <= vec_q;
                            ffvalid_q <= 1'b1;
                        end
                        vec_q <= vec_q + 1'b1;
                    end
                    ST_DONE: begin
                        done_q    <= 1'b1;
                        pass_q    <= (fail_q == '0) && !cfg_bad;
                        cfg_err_q <= cfg_bad;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gate_chip_tester.sv
// Directed bench for gate_chip_tester with a behavioural NAND/NOR chip model.
module tb_gate_chip_tester;

    logic        Clk = 1'b0;
    logic        Reset, Start, Abort;
    logic [2:0]  Func;
    logic [1:0]  NumInputs;
    logic [3:0]  GateMask;
    logic [3:0]  SenseOut;
    logic [11:0] DrvIn;
    logic        DrvEn, Busy, Done, Pass, ConfigErr;
    logic [3:0]  FailMask;
    logic [2:0]  FirstFailVec;
    logic        FirstFailValid;

    int n_checks = 0;
    int n_fail   = 0;

    // Chip model: each gate is a 3-input NAND or NOR on its DrvIn slice, with fault injection.
    logic       chip_nor;
    logic [3:0] stuck1, floating, float_rnd;

    always #5 Clk = ~Clk;

    always @(negedge Clk) float_rnd = 4'($urandom);

    always_comb begin
        for (int g = 0; g < 4; g++) begin
            SenseOut[g] = chip_nor ? ~|DrvIn[g*3 +: 3] : ~&DrvIn[g*3 +: 3];
            if (stuck1[g])   SenseOut[g] = 1'b1;
            if (floating[g]) SenseOut[g] = float_rnd[g];
        end
    end

    gate_chip_tester #(
        .NUM_GATES(4), .MAX_INPUTS(3), .SETTLE_CYCLES(4)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort),
        .Func(Func), .NumInputs(NumInputs), .GateMask(GateMask), .SenseOut(SenseOut),
        .DrvIn(DrvIn), .DrvEn(DrvEn), .Busy(Busy), .Done(Done), .Pass(Pass),
        .ConfigErr(ConfigErr), .FailMask(FailMask), .FirstFailVec(FirstFailVec),
        .FirstFailValid(FirstFailValid)
    );

    typedef struct {
        logic [2:0] func;
        logic [1:0] nin;
        logic [3:0] mask;
        logic       nor_chip;
        logic [3:0] stuck;
        logic [3:0] flt;
        int         cycles;
        logic       pass;
        logic       cfgerr;
        logic [3:0] fmask;
        logic [2:0] ffv;
        logic       ffvalid;
    } test_vec_t;

    test_vec_t tv[11];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_chip(input test_vec_t t);
        chip_nor = t.nor_chip;
        stuck1   = t.stuck;
        floating = t.flt;
    endtask

    // Start accepted on the first edge (cycle 0); cycles counted to the edge that raises Done.
    task automatic run_test(input int idx, input test_vec_t t);
        int  n;
        logic seen_en;
        set_chip(t);
        Func = t.func; NumInputs = t.nin; GateMask = t.mask;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        // Scramble config after accept; the latched copy must be used.
        Func = t.func ^ 3'd5; NumInputs = 2'd0; GateMask = ~t.mask;
        seen_en = DrvEn;
        n = 0;
        while (!Done && n < 200) begin
            tick();
            n++;
            if (DrvEn) seen_en = 1'b1;
        end
        chk($sformatf("t%0d_cycles", idx), n, t.cycles);
        chk($sformatf("t%0d_pass", idx), Pass, t.pass);
        chk($sformatf("t%0d_cfgerr", idx), ConfigErr, t.cfgerr);
        chk($sformatf("t%0d_failmask", idx), FailMask, t.fmask);
        chk($sformatf("t%0d_ffvalid", idx), FirstFailValid, t.ffvalid);
        if (t.ffvalid) chk($sformatf("t%0d_ffv", idx), FirstFailVec, t.ffv);
        chk($sformatf("t%0d_drven_seen", idx), seen_en, !t.cfgerr);
        chk($sformatf("t%0d_busy_at_done", idx), Busy, 0);
        tick();
        chk($sformatf("t%0d_done_pulse", idx), Done, 0);
        chk($sformatf("t%0d_pass_held", idx), Pass, t.pass);
    endtask

    initial begin
        //           func  nin  mask  nor  stuck flt   cyc pass cfg fmask  ffv   ffvld
        tv[0]  = '{3'd1, 2'd2, 4'hF, 1'b0, 4'h0, 4'h0, 25, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0}; // good 7400
        tv[1]  = '{3'd1, 2'd2, 4'hF, 1'b0, 4'h4, 4'h0, 25, 1'b0, 1'b0, 4'h4, 3'd3, 1'b1}; // gate2 stuck-1
        tv[2]  = '{3'd1, 2'd3, 4'h7, 1'b0, 4'h0, 4'h8, 49, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0}; // 7410, gate3 floating
        tv[3]  = '{3'd7, 2'd2, 4'hF, 1'b0, 4'h0, 4'h0,  2, 1'b0, 1'b1, 4'h0, 3'd0, 1'b0}; // INV with 2 inputs
        tv[4]  = '{3'd1, 2'd2, 4'h0, 1'b0, 4'h0, 4'h0,  2, 1'b0, 1'b1, 4'h0, 3'd0, 1'b0}; // empty GateMask
        tv[5]  = '{3'd0, 2'd0, 4'hF, 1'b0, 4'h0, 4'h0,  2, 1'b0, 1'b1, 4'h0, 3'd0, 1'b0}; // zero inputs
        tv[6]  = '{3'd4, 2'd2, 4'hF, 1'b0, 4'h0, 4'h0, 25, 1'b0, 1'b0, 4'hF, 3'd0, 1'b1}; // XOR vs NAND chip
        tv[7]  = '{3'd6, 2'd1, 4'hF, 1'b0, 4'h0, 4'h0, 13, 1'b0, 1'b0, 4'hF, 3'd0, 1'b1}; // BUF vs NAND chip
        tv[8]  = '{3'd7, 2'd1, 4'hA, 1'b0, 4'h0, 4'h0, 13, 1'b0, 1'b0, 4'hA, 3'd1, 1'b1}; // INV vs NAND chip
        tv[9]  = '{3'd0, 2'd2, 4'h3, 1'b1, 4'h0, 4'h0, 25, 1'b0, 1'b0, 4'h3, 3'd3, 1'b1}; // AND vs NOR chip
        tv[10] = '{3'd3, 2'd2, 4'hF, 1'b1, 4'h0, 4'h0, 25, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0}; // good 7402

        Reset = 1'b1; Start = 1'b0; Abort = 1'b0;
        Func = 3'd0; NumInputs = 2'd0; GateMask = 4'h0;
        chip_nor = 1'b0; stuck1 = 4'h0; floating = 4'h0;
        tick();
        tick();
        chk("rst_drvin", DrvIn, 0);
        chk("rst_drven", DrvEn, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_pass", Pass, 0);
        chk("rst_cfgerr", ConfigErr, 0);
        chk("rst_failmask", FailMask, 0);
        chk("rst_ffv", FirstFailVec, 0);
        chk("rst_ffvalid", FirstFailValid, 0);
        Reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) run_test(i, tv[i]);

        // Abort in the second SETTLE with a mid-test Start; NAND config on a NOR chip fails at v=0.
        chip_nor = 1'b1; stuck1 = 4'h0; floating = 4'h0;
        Func = 3'd1; NumInputs = 2'd2; GateMask = 4'hF;
        Start = 1'b1;
        tick();                                   // edge 0
        Start = 1'b0;
        tick(); tick();                           // edge 2
        Func = 3'd7; Start = 1'b1;                // would be an illegal config if accepted
        tick();                                   // edge 3
        Start = 1'b0;
        tick(); tick(); tick();                   // edge 6: APPLY of vector 1
        chk("abort_drvin_v1", DrvIn, 12'b101_101_101_101);
        chk("abort_drven_v1", DrvEn, 1);
        tick(); tick();                           // edge 8: in second SETTLE
        chk("abort_busy_before", Busy, 1);
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        chk("abort_busy", Busy, 0);
        chk("abort_drven", DrvEn, 0);
        chk("abort_drvin", DrvIn, 0);
        chk("abort_pass", Pass, 0);
        chk("abort_failmask_kept", FailMask, 4'hF);
        chk("abort_ffvalid_kept", FirstFailValid, 1);
        chk("abort_ffv_kept", FirstFailVec, 0);
        begin
            logic done_seen;
            done_seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (Done || Busy) done_seen = 1'b1;
            end
            chk("abort_no_done", done_seen, 0);
        end

        // Asynchronous reset in the middle of SETTLE
        Func = 3'd1; NumInputs = 2'd2; GateMask = 4'hF;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("rstmid_failmask_pre", FailMask, 4'hF);
        chk("rstmid_drven_pre", DrvEn, 1);
        Reset = 1'b1;
        #1;
        chk("rstmid_drven", DrvEn, 0);
        chk("rstmid_drvin", DrvIn, 0);
        chk("rstmid_busy", Busy, 0);
        chk("rstmid_failmask", FailMask, 0);
        chk("rstmid_ffvalid", FirstFailValid, 0);
        chk("rstmid_ffv", FirstFailVec, 0);
        tick();
        Reset = 1'b0;
        tick();
        run_test(10, tv[10]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
